uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the Arty S7 board top: takes the asynchronous `rxd` pin, recovers 8N1 frames (optional parity) by mid-bit sampling, and buffers received bytes in a small FIFO. The I/O bus reads the FIFO through a first-word-fall-through read port. Receive error conditions are exposed as sticky status flags.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer-truncated, and must be ≥ 4.
- `FIFO_DEPTH`, 16: byte entries, and must be a power of two ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input, idle high.
- `rd_en`  in  1  pop the head entry; ignored when `rx_valid` = 0.
- `clr_err`  in  1  clears `overrun` and `frame_err`.
- `rd_data`  out  8  head-of-FIFO byte, valid while `rx_valid` = 1.
- `rx_valid`  out  1  FIFO not empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  current number of stored bytes.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky flag: bad stop bit, or parity error when parity is enabled.

## Operation
- `rxd` passes through a 2-flop synchronizer, with both flops reset to 1, giving `rxs`. All logic below uses `rxs`.
- FSM states are IDLE, START, DATA, PARITY (only when parity is compiled in), STOP and WAIT_IDLE. A bit counter `cnt` counts 0..CLKS_PER_BIT-1. A bit index counts 0..7.
- **IDLE:** when `rxs` = 0, go to START with `cnt` = 0.
- **START:** at `cnt` = CLKS_PER_BIT/2 - 1, sample `rxs`.
  - If 1 (false start), return to IDLE.
  - If 0, go to DATA with `cnt` = 0. Every later sample is taken at `cnt` = CLKS_PER_BIT-1, which is mid-bit.
- **DATA:** shift samples in LSB first. After index 7, go to PARITY or STOP.
- **PARITY:** sample the parity bit and compare it with the even parity of the data. The result is held in a mismatch bit.
- **STOP:** sample the stop bit.
  - Sample is 1 with no mismatch: push the byte and go to IDLE.
  - Sample is 0: set `frame_err`, discard the byte, go to WAIT_IDLE.
  - Sample is 1 but parity mismatched: set `frame_err`, discard the byte, go to IDLE.
- **WAIT_IDLE:** stay until `rxs` = 1, then go to IDLE. A break condition therefore produces exactly one `frame_err` and no bytes.
- **FIFO:** circular buffer with read and write pointers one bit wider than the address.
  - A push when full drops the byte and sets `overrun`. FIFO contents are unchanged.
  - On a cycle with both push and an accepted pop, the pop is applied first. If the FIFO was full, the push succeeds and `count` is unchanged. If the FIFO was empty, only the push takes effect, because `rd_en` is ignored when empty.
  - Pointers wrap modulo 2·FIFO_DEPTH. Full means the addresses are equal and the MSBs differ.
- **Error flags:** `clr_err` clears them. If a set event and `clr_err` happen in the same cycle, the set wins.

## Timing
- Reset values: FSM in IDLE, FIFO empty, `rx_valid` = 0, `count` = 0, `rd_data` = 0x00, `overrun` = 0, `frame_err` = 0.
- Reset asserted mid-frame aborts the frame and flushes the FIFO.
- Pin to `rxs` latency is 2 cycles.
- Pin falling edge to the start-bit sample is CLKS_PER_BIT/2 + 2 cycles.
- The push occurs on the cycle of the stop-bit sample. `rx_valid`, `count` and `rd_data` update on the next edge.
- `rd_data` shows the head registered. After a pop, the next entry appears on the following edge.
- Back-to-back frames are supported: the FSM is in IDLE at the stop-bit midpoint, leaving half a bit for edge detection.
- Sustained throughput is one byte per frame time, with no dead cycles on the read side.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: frames are 8E1 and the PARITY state is present. A parity mismatch sets `frame_err` and discards the byte.
  - Undefined: frames are 8N1, the PARITY state and checker are absent, and `frame_err` reports stop-bit errors only.

## Test plan
All scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (10 clks/bit) and FIFO_DEPTH=4.
- **Single byte:** send 0xA5 (8N1). Required: `rx_valid` = 1 with `rd_data` = 0xA5 and `count` = 1. After `rd_en`, `rx_valid` = 0.
- **False start:** pulse `rxd` low for 3 clks. Required: no push, FSM back in IDLE, both flags 0.
- **Framing / break:** send 0x3C with stop bit = 0 and hold `rxd` low for 30 clks, then release. Required: `frame_err` = 1, `count` = 0. After `clr_err`, `frame_err` = 0.
- **Overrun:** send 0x01..0x05 back-to-back with no reads. Required: `count` = 4, `overrun` = 1, reads return 0x01, 0x02, 0x03, 0x04.
- **Full + simultaneous pop/push:** with 4 bytes stored, assert `rd_en` on the stop-sample cycle of a 5th byte 0x77. Required: no overrun, `count` stays 4, last read returns 0x77.
- **Parity (UART_RX_PARITY_EN):** send 0x03 with parity 0 (correct), then 0x07 with parity 0 (wrong). Required: only 0x03 is stored and `frame_err` = 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  logic          rx_meta, rxs;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          mismatch;
  logic          push, fe_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          mismatch <= 1'b0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            sh  <= {rxs, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            mismatch <= rxs ^ (^sh);
            state    <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The stop-bit sample cycle is the push cycle; FIFO state moves on the edge closing it.
  assign push   = (state == STOP) && (cnt == CNT_LAST) && rxs && !mismatch;
  assign fe_set = (state == STOP) && (cnt == CNT_LAST) && (!rxs || mismatch);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_n;
  logic        full, empty, pop, wr;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = rd_en && !empty;
  assign wr     = push && (!full || pop);
  assign rptr_n = rptr + (AW+1)'(pop);

  assign rx_valid = !empty;
  assign count    = wptr - rptr;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= sh;
  end

  // rd_data is loaded with the next head, bypassing the write when it lands on that slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      rd_data   <= 8'h00;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rptr <= rptr_n;
      if (wr) wptr <= wptr + 1'b1;
      if (wr && (wptr[AW-1:0] == rptr_n[AW-1:0])) rd_data <= sh;
      else                                         rd_data <= mem[rptr_n[AW-1:0]];
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;
      if (fe_set)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at 10 clks/bit, depth 4
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int STOP_C = NB * 10 - 3;

  logic       clk = 1'b0;
  logic       reset, rxd, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rx_valid, overrun, frame_err;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .count(count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame bit 0 is the start bit; rd_en is pulsed during cycle pop_at of the frame.
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b, input int pop_at);
    logic [10:0] f;
    if (NB == 11) f = {stop_b, par_b, d, 1'b0};
    else          f = {1'b1, stop_b, d, 1'b0};
    for (int c = 0; c < NB * 10; c++) begin
      rxd   = f[c / 10];
      rd_en = (c == pop_at);
      tick(1);
    end
    rd_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'h00);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_fe", {31'd0, frame_err}, 32'd0);

    send(8'hA5, 1'b1, ^8'hA5, -1);
    check("single_count", {29'd0, count}, 32'd1);
    read_chk("single", 8'hA5);
    check("single_empty", {31'd0, rx_valid}, 32'd0);

    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(20);
    check("false_count", {29'd0, count}, 32'd0);
    check("false_fe", {31'd0, frame_err}, 32'd0);
    check("false_ovr", {31'd0, overrun}, 32'd0);

    send(8'h3C, 1'b0, ^8'h3C, -1);
    tick(30);
    rxd = 1'b1;
    tick(20);
    check("break_fe", {31'd0, frame_err}, 32'd1);
    check("break_count", {29'd0, count}, 32'd0);
    clear_flags();
    check("break_clr", {31'd0, frame_err}, 32'd0);

    send(8'h5A, 1'b1, ^8'h5A, -1);
    read_chk("recover", 8'h5A);

    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, ^(8'(i)), -1);
    check("ovr_count", {29'd0, count}, 32'd4);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) read_chk($sformatf("ovr_rd%0d", i), 8'(i));
    check("ovr_drained", {29'd0, count}, 32'd0);
    clear_flags();
    check("ovr_clr", {31'd0, overrun}, 32'd0);

    send(8'h11, 1'b1, ^8'h11, -1);
    send(8'h22, 1'b1, ^8'h22, -1);
    send(8'h33, 1'b1, ^8'h33, -1);
    send(8'h44, 1'b1, ^8'h44, -1);
    check("full_count", {29'd0, count}, 32'd4);
    send(8'h77, 1'b1, ^8'h77, STOP_C);
    check("sim_ovr", {31'd0, overrun}, 32'd0);
    check("sim_count", {29'd0, count}, 32'd4);
    read_chk("sim_rd0", 8'h22);
    read_chk("sim_rd1", 8'h33);
    read_chk("sim_rd2", 8'h44);
    read_chk("sim_rd3", 8'h77);
    check("sim_empty", {31'd0, rx_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1, 1'b0, -1);
    send(8'h07, 1'b1, 1'b0, -1);
    tick(5);
    check("par_count", {29'd0, count}, 32'd1);
    check("par_fe", {31'd0, frame_err}, 32'd1);
    read_chk("par_rd", 8'h03);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
